// File: rtl/seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_divider                                                   |
// | Purpose  : 32-cycle restoring divider, MIPS DIV/DIVU semantics (HI/LO).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_ITER = 5'd31;

    state_t           r_state;
    state_t           w_next;
    logic [4:0]       r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dvz;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_lo_fix;

    assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Trial subtraction on the shifted remainder; bit WIDTH is the borrow/sign.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvsr};

    // Negating the remainder magnitude also reproduces the raw dividend for /0.
    assign w_hi_fix = r_neg_r ? -r_rem : r_rem;
    assign w_lo_fix = r_dvz ? '1 : (r_neg_q ? -r_quo : r_quo);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_ITER;
            S_ITER: if (r_cnt == c_LAST_ITER) w_next = S_SIGN;
            S_SIGN: w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dvz   <= 1'b0;
            r_dvsr  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r <= is_signed & dividend[WIDTH-1];
                        r_dvz   <= (divisor == '0);
                        r_dvsr  <= w_dvs_mag;
                        r_quo   <= w_dvd_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_ITER: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                S_SIGN: begin
                    r_hi  <= w_hi_fix;
                    r_lo  <= w_lo_fix;
                    r_dbz <= r_dvz;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_divider                                                |
// | Purpose  : Directed and random checks of seq_divider against a model.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;

    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;
    logic        prev_dbz = 1'b0;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // MIPS reference: {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (!s) return {1'b0, a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
        qq = q; rr = r;
        return {1'b0, rr, qq};
    endfunction

    // One operation; dk = edge index to inject an ignored start, rk = edge index to reset.
    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input int dk, input int rk);
        logic [64:0] e;
        bit seen;
        e = model(s, a, b);
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = ~s;
        check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            if (k == rk) begin
                reset = 1'b1; #1;
                check({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                check({tag, "_rst_done"}, {31'd0, done}, 32'd0);
                check({tag, "_rst_hi"}, hi, 32'd0);
                check({tag, "_rst_lo"}, lo, 32'd0);
                check({tag, "_rst_dbz"}, {31'd0, div_by_zero}, 32'd0);
                @(negedge clk); reset = 1'b0;
                prev_hi = '0; prev_lo = '0; prev_dbz = 1'b0;
                seen = 1'b0;
                for (int j = 0; j < 40; j++) begin
                    @(posedge clk); #1;
                    if (done || busy) seen = 1'b1;
                end
                check({tag, "_no_done_after_rst"}, {31'd0, seen}, 32'd0);
                return;
            end
            if (k == dk) begin
                start = 1'b1; dividend = $urandom; divisor = $urandom; is_signed = ~s;
            end
            if (k == dk + 1) start = 1'b0;
            if (k < 33) begin
                if (done !== 1'b0) check({tag, "_early_done"}, {31'd0, done}, 32'd0);
                if (busy !== 1'b1) check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
            end
            if (k == 32) begin
                check({tag, "_hold_hi"}, hi, prev_hi);
                check({tag, "_hold_lo"}, lo, prev_lo);
                check({tag, "_hold_dbz"}, {31'd0, div_by_zero}, {31'd0, prev_dbz});
            end
            if (k == 33) begin
                check({tag, "_done"}, {31'd0, done}, 32'd1);
                check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
                check({tag, "_lo"}, lo, e[31:0]);
                check({tag, "_hi"}, hi, e[63:32]);
                check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e[64]});
                prev_lo = e[31:0]; prev_hi = e[63:32]; prev_dbz = e[64];
                start = 1'b1;
            end
            if (k == 34) begin
                start = 1'b0;
                check({tag, "_done_end"}, {31'd0, done}, 32'd0);
                check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
            end
        end
        @(posedge clk); #1;
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk); reset = 1'b0;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, -1, -1);
        run_op("div_m7_2", 1'b1, -32'sd7, 32'd2, -1, -1);
        run_op("div_7_m2", 1'b1, 32'd7, -32'sd2, -1, -1);
        run_op("div_by_0", 1'b1, 32'h1234_5678, 32'd0, -1, -1);
        run_op("div_9_3", 1'b1, 32'd9, 32'd3, -1, -1);
        run_op("div_neg_by_0", 1'b1, 32'h8765_4321, 32'd0, -1, -1);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op("ignore_start", 1'b0, 32'hDEAD_BEEF, 32'd13, 10, -1);
        run_op("mid_reset", 1'b1, 32'd1000, 32'd7, -1, 20);
        run_op("div_50_5", 1'b0, 32'd50, 32'd5, -1, -1);

        for (int i = 0; i < 24; i++) begin
            rs = $urandom_range(0, 1);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = -32'($urandom_range(1, 15));
                2: rb = (i % 8 == 0) ? 32'd0 : $urandom;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op("rand", rs, ra, rb, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 dividend  input  32  numerator; sampled with start.
REQ-007 divisor  input  32  denominator; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when results are valid.
REQ-010 hi  output  32  remainder (MIPS HI).
REQ-011 lo  output  32  quotient (MIPS LO).
REQ-012 div_by_zero  output  1  set with done when the latched divisor was 0.

Function
REQ-013 The FSM SHALL have states IDLE, ITER, SIGN, DONE; every output is registered.
REQ-014 IDLE with start=1: latch is_signed, sign bits and magnitudes of both operands (unsigned mode: raw values), clear the 32-bit partial remainder and the 5-bit iteration counter, go to ITER, busy=1.
REQ-015 IDLE with start=0: stay in IDLE, no register changes.
REQ-016 ITER: one restoring step per cycle: shift {remainder, quotient} left 1, subtract divisor magnitude from the 33-bit trial, keep the result and set quotient LSB=1 when non-negative, else restore and set LSB=0.
REQ-017 ITER SHALL run exactly 32 cycles (counter 0..31), then go to SIGN.
REQ-018 SIGN, signed mode: negate the quotient when the operand signs differ; negate the remainder when the dividend is negative (truncation toward zero).
REQ-019 SIGN, unsigned mode: pass values unchanged; then go to DONE.
REQ-020 DONE: load hi/lo, set done=1 for exactly one cycle, then return to IDLE with busy=0 and done=0.
REQ-021 Latency SHALL be fixed: done is high in the cycle after the 33rd edge following the edge that sampled start; busy is high for 34 cycles.
REQ-022 hi/lo SHALL change only on entry to DONE and hold their values otherwise, including throughout a following operation.
REQ-023 start, operands and is_signed SHALL be ignored while busy=1; a start concurrent with the DONE->IDLE edge is ignored.
REQ-024 Divisor 0: same latency; lo=0xFFFFFFFF, hi=dividend (raw input value), div_by_zero=1 with done; otherwise div_by_zero=0 with done.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0, div_by_zero=0 (wrap, no trap).
REQ-026 div_by_zero SHALL hold until the next DONE.

Reset
REQ-027 reset=1 SHALL at once force IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0 and clear the counter, at any time, including mid-ITER.
REQ-028 After reset deasserts, the first rising edge with start=1 SHALL begin a fresh operation; no partial result ever appears on hi/lo.

Verification
REQ-029 DIVU: 100 / 7 -> done 33 edges after start, lo=14, hi=2, busy low the next cycle.
REQ-030 DIV: -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; 7 / -2 -> lo=0xFFFFFFFD, hi=1.
REQ-031 DIV by zero: 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1; a following 9/3 -> lo=3, hi=0, div_by_zero=0.
REQ-032 Overflow: signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; unsigned same operands -> lo=0, hi=0x80000000.
REQ-033 Start pulsed and operands changed at ITER cycle 10 -> ignored, original result delivered unchanged.
REQ-034 Reset asserted at ITER cycle 20 -> all outputs 0 immediately, no done pulse; new 50/5 completes with lo=10, hi=0.
